breakout_block_column: RTL and testbench

Parametrised successor to the fixed eight-row block column in the breakout playfield.
- Each block holds a multi-hit point counter instead of a single alive bit.
- Detects ball contact on all four block faces and arbitrates to one hit per event.
- Applies a post-hit cooldown, counts destroyed blocks, and flags when the column is clear.
- One instance per column; bounce pulses are OR-ed in the ball controller, and pixel outputs feed the VGA colour mux.

---
 rtl/breakout_block_column.sv | 207 ++++++++++++++++++++
 tb/tb_breakout_block_column.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/breakout_block_column.sv
// One column of multi-hit breakout blocks: face contact detection, one hit per event, post-hit cooldown, clear flag.
// Optional macro BREAKOUT_HIT_STATS_EN adds the 16-bit saturating total_hits output.
module breakout_block_column #(
  parameter int ROWS       = 8,
  parameter int X_LEFT     = 149,
  parameter int X_RIGHT    = 164,
  parameter int Y_TOP      = 4,
  parameter int ROW_PITCH  = 74,
  parameter int ROW_HEIGHT = 72,
  parameter int EDGE       = 3,
  parameter int EXT        = 7,
  parameter int HP_W       = 2,
  parameter int HP_INIT    = 1,
  parameter int COOLDOWN   = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         rebuild,
  input  logic [10:0]                  pix_x,
  input  logic [10:0]                  pix_y,
  input  logic [10:0]                  ball_x_l,
  input  logic [10:0]                  ball_x_r,
  input  logic [10:0]                  ball_y_t,
  input  logic [10:0]                  ball_y_b,
  output logic                         moveU,
  output logic                         moveD,
  output logic                         moveL,
  output logic                         moveR,
  output logic                         hit_valid,
  output logic [3:0]                   hit_row,
  output logic [$clog2(ROWS+1)-1:0]    destroyed_count,
  output logic                         column_clear,
  output logic                         blk_on,
  output logic [HP_W-1:0]              blk_hp
`ifdef BREAKOUT_HIT_STATS_EN
  ,
  output logic [15:0]                  total_hits
`endif
);

  localparam int CNT_W = $clog2(ROWS+1);
  localparam int CD_W  = (COOLDOWN < 2) ? 1 : $clog2(COOLDOWN+1);

  localparam logic [10:0] XL     = 11'(X_LEFT);
  localparam logic [10:0] XR     = 11'(X_RIGHT);
  localparam logic [10:0] XL_IN  = 11'(X_LEFT + EDGE);
  localparam logic [10:0] XR_IN  = 11'(X_RIGHT - EDGE);
  localparam logic [10:0] XL_EXT = 11'(X_LEFT - EXT);
  localparam logic [10:0] XR_EXT = 11'(X_RIGHT + EXT);
  localparam logic [HP_W-1:0] HP_LOAD = HP_W'(HP_INIT);

  typedef enum logic {IDLE, COOL} state_t;

  function automatic logic [HP_W-1:0] hp_dec(input logic [HP_W-1:0] hp);
    return (hp == '0) ? '0 : hp - HP_W'(1);
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t            state_p1, state_nxt;
  logic [CD_W-1:0]   cd_p1, cd_nxt;
  logic [HP_W-1:0]   hp_p1  [ROWS];
  logic [HP_W-1:0]   hp_nxt [ROWS];
  logic [ROWS-1:0]   f_u, f_d, f_l, f_r, pix_in;

  logic              found_p0, hit_p0;
  logic [3:0]        win_p0;
  logic              mu_p0, md_p0, ml_p0, mr_p0;
  logic [CNT_W-1:0]  dead_nxt;
  logic              clear_nxt;

  logic              mu_p1, md_p1, ml_p1, mr_p1, vld_p1;
  logic [3:0]        row_p1;
  logic [CNT_W-1:0]  dead_p1;
  logic              clear_p1;

  // Stage 0: per-row face windows and pixel containment from the current hp array
  for (genvar g = 0; g < ROWS; g++) begin : g_row
    localparam logic [10:0] TOP    = 11'(Y_TOP + g*ROW_PITCH);
    localparam logic [10:0] TOP_IN = 11'(Y_TOP + g*ROW_PITCH + EDGE);
    localparam logic [10:0] BOT    = 11'(Y_TOP + g*ROW_PITCH + ROW_HEIGHT);
    localparam logic [10:0] BOT_IN = 11'(Y_TOP + g*ROW_PITCH + ROW_HEIGHT - EDGE);
    logic live, y_ov, x_ext;
    assign live  = |hp_p1[g];
    assign y_ov  = (ball_y_b >= TOP) && (ball_y_t <= BOT);
    assign x_ext = (ball_x_r <= XR_EXT) && (ball_x_l >= XL_EXT);
    assign f_r[g] = live && y_ov && (ball_x_l >= XR_IN) && (ball_x_l <= XR);
    assign f_l[g] = live && y_ov && (ball_x_r >= XL) && (ball_x_r <= XL_IN);
    assign f_d[g] = live && x_ext && (ball_y_t >= BOT_IN) && (ball_y_t <= BOT);
    assign f_u[g] = live && x_ext && (ball_y_b >= TOP) && (ball_y_b <= TOP_IN);
    assign pix_in[g] = live && (pix_x >= XL) && (pix_x <= XR) && (pix_y >= TOP) && (pix_y <= BOT);
  end

  always_comb begin
    found_p0 = 1'b0;
    win_p0   = '0;
    mu_p0    = 1'b0;
    md_p0    = 1'b0;
    ml_p0    = 1'b0;
    mr_p0    = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      if (!found_p0 && (f_u[r] || f_d[r] || f_l[r] || f_r[r])) begin
        found_p0 = 1'b1;
        win_p0   = 4'(r);
        mu_p0    = f_u[r];
        md_p0    = f_d[r];
        ml_p0    = f_l[r];
        mr_p0    = f_r[r];
      end
    end
  end

  assign hit_p0 = found_p0 && (state_p1 == IDLE);

  always_comb begin
    state_nxt = state_p1;
    cd_nxt    = cd_p1;
    case (state_p1)
      IDLE: if (hit_p0 && (COOLDOWN != 0)) begin
        state_nxt = COOL;
        cd_nxt    = CD_W'(COOLDOWN);
      end
      COOL: if (cd_p1 <= CD_W'(1)) begin
        state_nxt = IDLE;
        cd_nxt    = '0;
      end else begin
        cd_nxt = cd_p1 - CD_W'(1);
      end
      default: begin
        state_nxt = IDLE;
        cd_nxt    = '0;
      end
    endcase
  end

  always_comb begin
    dead_nxt = '0;
    for (int r = 0; r < ROWS; r++) begin
      hp_nxt[r] = (hit_p0 && (win_p0 == 4'(r))) ? hp_dec(hp_p1[r]) : hp_p1[r];
      if (hp_nxt[r] == '0) dead_nxt = dead_nxt + CNT_W'(1);
    end
    clear_nxt = (dead_nxt == CNT_W'(ROWS));
  end

  // Stage 1: registered hit pulses, hp array and column status
  always_ff @(posedge clk) begin
    if (!reset || rebuild) begin
      state_p1 <= IDLE;
      cd_p1    <= '0;
      for (int r = 0; r < ROWS; r++) hp_p1[r] <= HP_LOAD;
      mu_p1    <= 1'b0;
      md_p1    <= 1'b0;
      ml_p1    <= 1'b0;
      mr_p1    <= 1'b0;
      vld_p1   <= 1'b0;
      row_p1   <= '0;
      dead_p1  <= '0;
      clear_p1 <= 1'b0;
    end else begin
      state_p1 <= state_nxt;
      cd_p1    <= cd_nxt;
      for (int r = 0; r < ROWS; r++) hp_p1[r] <= hp_nxt[r];
      mu_p1    <= hit_p0 && mu_p0;
      md_p1    <= hit_p0 && md_p0;
      ml_p1    <= hit_p0 && ml_p0;
      mr_p1    <= hit_p0 && mr_p0;
      vld_p1   <= hit_p0;
      row_p1   <= hit_p0 ? win_p0 : 4'd0;
      dead_p1  <= dead_nxt;
      clear_p1 <= clear_nxt;
    end
  end

  assign moveU           = mu_p1;
  assign moveD           = md_p1;
  assign moveL           = ml_p1;
  assign moveR           = mr_p1;
  assign hit_valid       = vld_p1;
  assign hit_row         = row_p1;
  assign destroyed_count = dead_p1;
  assign column_clear    = clear_p1;

`ifdef BREAKOUT_HIT_STATS_EN
  // Rebuild leaves the lifetime hit count alone; only reset clears it
  logic [15:0] hits_p1;
  always_ff @(posedge clk) begin
    if (!reset) hits_p1 <= '0;
    else if (!rebuild && hit_p0) hits_p1 <= sat_inc16(hits_p1);
  end
  assign total_hits = hits_p1;
`endif

  // Lowest live row under the pixel supplies the colour hp
  always_comb begin
    blk_on = 1'b0;
    blk_hp = '0;
    for (int r = ROWS-1; r >= 0; r--) begin
      if (pix_in[r]) begin
        blk_on = 1'b1;
        blk_hp = hp_p1[r];
      end
    end
  end

endmodule

// File: tb/tb_breakout_block_column.sv
// Bench for breakout_block_column: two instances (HP_INIT 1 and 2) against a behavioural column model.
module tb_breakout_block_column;
  localparam int ROWS = 8, XL = 149, XR = 164, YT = 4, PITCH = 74, RH = 72;
  localparam int EDGE = 3, EXT = 7, CD = 4;

  int HPI [2] = '{1, 2};

  logic clk = 1'b0;
  logic reset = 1'b0, rebuild = 1'b0;
  logic [10:0] pix_x = 11'd150, pix_y = 11'd10;
  logic [10:0] bxl = 11'd600, bxr = 11'd607, byt = 11'd700, byb = 11'd707;

  logic mu [2], md [2], ml [2], mr [2], hv [2], clr [2], bon [2];
  logic [3:0] hrow [2], dc [2];
  logic [1:0] bhp [2];
`ifdef BREAKOUT_HIT_STATS_EN
  logic [15:0] th [2];
`endif

  breakout_block_column #(.HP_INIT(1), .COOLDOWN(CD)) dut (
    .clk(clk), .reset(reset), .rebuild(rebuild), .pix_x(pix_x), .pix_y(pix_y),
    .ball_x_l(bxl), .ball_x_r(bxr), .ball_y_t(byt), .ball_y_b(byb),
    .moveU(mu[0]), .moveD(md[0]), .moveL(ml[0]), .moveR(mr[0]),
    .hit_valid(hv[0]), .hit_row(hrow[0]), .destroyed_count(dc[0]),
    .column_clear(clr[0]), .blk_on(bon[0]), .blk_hp(bhp[0])
`ifdef BREAKOUT_HIT_STATS_EN
    , .total_hits(th[0])
`endif
  );

  breakout_block_column #(.HP_INIT(2), .COOLDOWN(CD)) dut2 (
    .clk(clk), .reset(reset), .rebuild(rebuild), .pix_x(pix_x), .pix_y(pix_y),
    .ball_x_l(bxl), .ball_x_r(bxr), .ball_y_t(byt), .ball_y_b(byb),
    .moveU(mu[1]), .moveD(md[1]), .moveL(ml[1]), .moveR(mr[1]),
    .hit_valid(hv[1]), .hit_row(hrow[1]), .destroyed_count(dc[1]),
    .column_clear(clr[1]), .blk_on(bon[1]), .blk_hp(bhp[1])
`ifdef BREAKOUT_HIT_STATS_EN
    , .total_hits(th[1])
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;

  int m_hp [2][ROWS];
  int m_blk [2], m_stats [2];
  bit e_mu [2], e_md [2], e_ml [2], e_mr [2], e_hv [2], e_clr [2];
  int e_row [2], e_dc [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // Column model: rows laid out by arithmetic, cooldown as a count of blocked cycles
  task automatic model_edge(input int i);
    int w, top, bot;
    bit fu, fd, fl, fr, yov, xw;
    e_mu[i] = 0; e_md[i] = 0; e_ml[i] = 0; e_mr[i] = 0; e_hv[i] = 0; e_row[i] = 0;
    if (!reset || rebuild) begin
      for (int r = 0; r < ROWS; r++) m_hp[i][r] = HPI[i];
      m_blk[i] = 0;
      if (!reset) m_stats[i] = 0;
    end else if (m_blk[i] > 0) begin
      m_blk[i]--;
    end else begin
      w = -1;
      for (int r = 0; r < ROWS; r++) begin
        top = YT + r*PITCH; bot = top + RH;
        yov = (int'(byb) >= top) && (int'(byt) <= bot);
        xw  = (int'(bxr) <= XR+EXT) && (int'(bxl) >= XL-EXT);
        fr = yov && int'(bxl) >= XR-EDGE && int'(bxl) <= XR;
        fl = yov && int'(bxr) >= XL && int'(bxr) <= XL+EDGE;
        fd = xw && int'(byt) >= bot-EDGE && int'(byt) <= bot;
        fu = xw && int'(byb) >= top && int'(byb) <= top+EDGE;
        if (w < 0 && m_hp[i][r] > 0 && (fu || fd || fl || fr)) begin
          w = r; e_mu[i] = fu; e_md[i] = fd; e_ml[i] = fl; e_mr[i] = fr;
        end
      end
      if (w >= 0) begin
        m_hp[i][w]--;
        e_hv[i] = 1; e_row[i] = w; m_blk[i] = CD;
        if (m_stats[i] < 65535) m_stats[i]++;
      end
    end
    e_dc[i] = 0;
    for (int r = 0; r < ROWS; r++) if (m_hp[i][r] == 0) e_dc[i]++;
    e_clr[i] = (e_dc[i] == ROWS);
  endtask

  task automatic check_all();
    bit eon; int ehp, top;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("moveU[%0d]", i), 32'(mu[i]), 32'(e_mu[i]));
      chk($sformatf("moveD[%0d]", i), 32'(md[i]), 32'(e_md[i]));
      chk($sformatf("moveL[%0d]", i), 32'(ml[i]), 32'(e_ml[i]));
      chk($sformatf("moveR[%0d]", i), 32'(mr[i]), 32'(e_mr[i]));
      chk($sformatf("hit_valid[%0d]", i), 32'(hv[i]), 32'(e_hv[i]));
      if (e_hv[i]) chk($sformatf("hit_row[%0d]", i), 32'(hrow[i]), 32'(e_row[i]));
      chk($sformatf("destroyed[%0d]", i), 32'(dc[i]), 32'(e_dc[i]));
      chk($sformatf("clear[%0d]", i), 32'(clr[i]), 32'(e_clr[i]));
      eon = 0; ehp = 0;
      for (int r = ROWS-1; r >= 0; r--) begin
        top = YT + r*PITCH;
        if (m_hp[i][r] > 0 && int'(pix_x) >= XL && int'(pix_x) <= XR &&
            int'(pix_y) >= top && int'(pix_y) <= top + RH) begin
          eon = 1; ehp = m_hp[i][r];
        end
      end
      chk($sformatf("blk_on[%0d]", i), 32'(bon[i]), 32'(eon));
      chk($sformatf("blk_hp[%0d]", i), 32'(bhp[i]), 32'(ehp));
`ifdef BREAKOUT_HIT_STATS_EN
      chk($sformatf("total_hits[%0d]", i), 32'(th[i]), 32'(m_stats[i]));
`endif
    end
  endtask

  task automatic step();
    model_edge(0);
    model_edge(1);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic park();
    bxl = 11'd600; bxr = 11'd607; byt = 11'd700; byb = 11'd707;
  endtask

  task automatic left_face(input int r);
    bxl = 11'd143; bxr = 11'd150;
    byt = 11'(YT + r*PITCH + 10); byb = 11'(YT + r*PITCH + 20);
  endtask

  initial begin
    #2;
    // Reset two cycles, then release
    reset = 0; step(); step();
    reset = 1; park(); step();
    chk("t1_destroyed", 32'(dc[0]), 32'd0);
    chk("t1_clear", 32'(clr[0]), 32'd0);
    chk("t1_blk_on", 32'(bon[0]), 32'd1);
    chk("t1_blk_hp", 32'(bhp[0]), 32'd1);

    // Right-face hit on row 1
    bxl = 11'd163; bxr = 11'd170; byt = 11'd80; byb = 11'd90; pix_y = 11'd100;
    step();
    chk("t2_moveR", 32'(mr[0]), 32'd1);
    chk("t2_hit_valid", 32'(hv[0]), 32'd1);
    chk("t2_hit_row", 32'(hrow[0]), 32'd1);
    chk("t2_destroyed", 32'(dc[0]), 32'd1);
    chk("t2_blk_on", 32'(bon[0]), 32'd0);
    park(); step();
    chk("t2_pulse_end", 32'(mr[0]), 32'd0);

    // Held bottom-face contact with cooldown, HP_INIT=2 instance
    reset = 0; step(); reset = 1;
    bxl = 11'd150; bxr = 11'd157; byt = 11'd75; byb = 11'd82; pix_y = 11'd10;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk($sformatf("t3_moveD_cyc%0d", k), 32'(md[1]), ((k == 1) || (k == 6)) ? 32'd1 : 32'd0);
    end
    chk("t3_hp0", 32'(bhp[1]), 32'd0);

    // Overlap of row 0 bottom and row 1 top: row 0 wins
    reset = 0; step(); reset = 1;
    bxl = 11'd150; bxr = 11'd157; byt = 11'd75; byb = 11'd79;
    step();
    chk("t4_hit_row", 32'(hrow[0]), 32'd0);
    chk("t4_moveD", 32'(md[0]), 32'd1);
    chk("t4_moveU", 32'(mu[0]), 32'd0);
    park(); repeat (5) step();

    // Destroy every row, then rebuild coincident with a hit
    reset = 0; step(); reset = 1;
    for (int r = 0; r < ROWS; r++) begin
      left_face(r); step();
      park(); repeat (5) step();
    end
    chk("t5_clear", 32'(clr[0]), 32'd1);
    chk("t5_destroyed", 32'(dc[0]), 32'd8);
    left_face(7); rebuild = 1; step(); rebuild = 0;
    chk("t5_hit_valid0", 32'(hv[0]), 32'd0);
    chk("t5_hit_valid1", 32'(hv[1]), 32'd0);
    chk("t5_clear_after", 32'(clr[0]), 32'd0);
    chk("t5_destroyed_after", 32'(dc[0]), 32'd0);
    park(); step();

`ifdef BREAKOUT_HIT_STATS_EN
    reset = 0; step(); reset = 1;
    for (int r = 0; r < 3; r++) begin left_face(r); step(); park(); repeat (5) step(); end
    rebuild = 1; step(); rebuild = 0;
    for (int r = 0; r < 2; r++) begin left_face(r); step(); park(); repeat (5) step(); end
    chk("t6_total_hits", 32'(th[0]), 32'd5);
    reset = 0; step(); reset = 1;
    chk("t6_total_hits_reset", 32'(th[0]), 32'd0);
`endif

    // Randomized contact sweep with sporadic rebuild/reset
    for (int n = 0; n < 600; n++) begin
      bxl = 11'($urandom_range(130, 175));
      bxr = bxl + 11'($urandom_range(0, 10));
      byt = 11'($urandom_range(0, 620));
      byb = byt + 11'($urandom_range(0, 10));
      pix_x = 11'($urandom_range(140, 170));
      pix_y = 11'($urandom_range(0, 620));
      rebuild = ($urandom_range(0, 39) == 0);
      reset = !($urandom_range(0, 149) == 0);
      step();
    end
    rebuild = 0; reset = 1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
